// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision adder datapath.
// Holds the binary32 field view, the canonical special encodings and the
// register bundle passed from the align stage to the add stage.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    // Everything stage 2 needs to finish the add, plus the special-case path.
    typedef struct packed {
        logic        special;
        logic [31:0] specialResult;
        logic [7:0]  expL;
        logic [23:0] manL;
        logic [23:0] shifted;
        logic        sticky;
        logic        signL;
        logic        effSub;
        logic        bothZero;
        logic        zeroSign;
    } align_stage_t;

    // Infinity carrying the requested sign.
    function automatic logic [31:0] signedInf(input logic s);
        return {s, POS_INF[30:0]};
    endfunction

endpackage

// File: rtl/fp_shift_sticky.sv
// Combinational 24-bit right shifter that also reports whether any set bit
// fell off the bottom. Shift amounts of 25 or more saturate to an all-zero
// result with the whole input folded into sticky.
// Ports:
//   sigIn    - significand to shift
//   shiftAmt - exponent difference (right-shift count)
//   sigOut   - shifted significand
//   sticky   - OR of every bit shifted out below bit 0
module fp_shift_sticky (
    input  logic [23:0] sigIn,
    input  logic [7:0]  shiftAmt,
    output logic [23:0] sigOut,
    output logic        sticky
);

    // Shift with saturation; the mask covers exactly the bits that drop out.
    always_comb begin
        sigOut = 24'h00_0000;
        sticky = 1'b0;
        if (shiftAmt >= 8'd25) begin
            sigOut = 24'h00_0000;
            sticky = |sigIn;
        end else begin
            sigOut = sigIn >> shiftAmt;
            // For shiftAmt=0 the mask is empty; for 24 it is all ones.
            sticky = |(sigIn & ~(24'hFF_FFFF << shiftAmt));
        end
    end

endmodule

// File: rtl/fp_align_add.sv
// Two-stage align-and-add front end of the binary32 adder, feeding the
// normalize/round stage. Stage 1 decodes specials, orders the operands by
// magnitude and aligns the smaller one; stage 2 adds/subtracts and fixes
// carry-out. Valid/ready handshake, one transfer per cycle, latency 2.
// Ports:
//   clk, reset            - clock, async active-high reset
//   in_valid/in_ready     - operand handshake (opA, opB, sub: 1 = A-B)
//   out_valid/out_ready   - result handshake toward normalization
//   alignedResult         - 24-bit significand result
//   exponentOut           - exponent of larger operand (+1 on carry-out)
//   alignedSign           - result sign
//   stickyBit             - OR of bits lost below bit 0
//   specialValid          - specialResult must be passed through unchanged
//   specialResult         - Inf/NaN encoding when specialValid, else 0
module fp_align_add
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   opA,
    input  logic [EXP_W+MAN_W:0]   opB,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAN_W:0]         alignedResult,
    output logic [EXP_W-1:0]       exponentOut,
    output logic                   alignedSign,
    output logic                   stickyBit,
    output logic                   specialValid,
    output logic [EXP_W+MAN_W:0]   specialResult
);

    // All-ones exponent marks Inf/NaN.
    localparam logic [7:0] EXP_ALL1 = 8'(2 * BIAS + 1);
    // Largest finite exponent; a carry from here overflows to Inf.
    localparam logic [7:0] EXP_TOP  = EXP_MAX - 8'd1;

    fp32_t        a_s, b_s;
    logic         signBEff_s, aZero_s, bZero_s, aNan_s, bNan_s, aInf_s, bInf_s, aIsL_s;
    logic [23:0]  manA_s, manB_s, manS_s, shifted_s;
    logic [7:0]   expDiff_s;
    logic         shiftSticky_s;
    align_stage_t s1Next_s, s1_r;
    logic         s1Valid_r, s2Valid_r, s1Load_s, s2Load_s;
    logic [24:0]  sum25_s;
    logic [23:0]  diff_s, resNext_s, alignedResult_r;
    logic [7:0]   expNext_s, exponentOut_r;
    logic         signNext_s, stickyNext_s, spValidNext_s;
    logic         alignedSign_r, stickyBit_r, specialValid_r;
    logic [31:0]  spResultNext_s, specialResult_r;

    assign a_s = fp32_t'(opA);
    assign b_s = fp32_t'(opB);

    // Handshake: a stage loads when it is empty or its contents move on.
    assign s2Load_s = !s2Valid_r || out_ready;
    assign s1Load_s = !s1Valid_r || s2Load_s;
    assign in_ready = s1Load_s;

    assign signBEff_s = b_s.sign ^ sub;
    assign aZero_s    = (a_s.exp == 8'h00);
    assign bZero_s    = (b_s.exp == 8'h00);
    assign aNan_s     = (a_s.exp == EXP_ALL1) && (a_s.frac != 23'h0);
    assign bNan_s     = (b_s.exp == EXP_ALL1) && (b_s.frac != 23'h0);
    assign aInf_s     = (a_s.exp == EXP_ALL1) && (a_s.frac == 23'h0);
    assign bInf_s     = (b_s.exp == EXP_ALL1) && (b_s.frac == 23'h0);
    // Zero exponent flushes the operand: implicit bit and fraction both dropped.
    assign manA_s     = aZero_s ? 24'h00_0000 : {1'b1, a_s.frac};
    assign manB_s     = bZero_s ? 24'h00_0000 : {1'b1, b_s.frac};
    // Ties go to A so the larger operand is always well defined.
    assign aIsL_s     = {a_s.exp, a_s.frac} >= {b_s.exp, b_s.frac};
    assign manS_s     = aIsL_s ? manB_s : manA_s;
    assign expDiff_s  = aIsL_s ? (a_s.exp - b_s.exp) : (b_s.exp - a_s.exp);

    fp_shift_sticky u_shift (
        .sigIn    (manS_s),
        .shiftAmt (expDiff_s),
        .sigOut   (shifted_s),
        .sticky   (shiftSticky_s)
    );

    // Stage-1 bundle: special resolution or the aligned operand pair.
    always_comb begin
        s1Next_s = '0;
        if (aNan_s || bNan_s) begin
            s1Next_s.special       = 1'b1;
            s1Next_s.specialResult = QNAN;
        end else if (aInf_s && bInf_s) begin
            s1Next_s.special       = 1'b1;
            s1Next_s.specialResult = (a_s.sign == signBEff_s) ? signedInf(a_s.sign) : QNAN;
        end else if (aInf_s) begin
            s1Next_s.special       = 1'b1;
            s1Next_s.specialResult = signedInf(a_s.sign);
        end else if (bInf_s) begin
            s1Next_s.special       = 1'b1;
            s1Next_s.specialResult = signedInf(signBEff_s);
        end else begin
            s1Next_s.expL     = aIsL_s ? a_s.exp : b_s.exp;
            s1Next_s.manL     = aIsL_s ? manA_s : manB_s;
            s1Next_s.shifted  = shifted_s;
            s1Next_s.sticky   = shiftSticky_s;
            s1Next_s.signL    = aIsL_s ? a_s.sign : signBEff_s;
            // Effective subtract depends only on the two effective signs.
            s1Next_s.effSub   = a_s.sign ^ signBEff_s;
            s1Next_s.bothZero = aZero_s && bZero_s;
            s1Next_s.zeroSign = a_s.sign & signBEff_s;
        end
    end

    // Stage-1 register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_r <= 1'b0;
            s1_r      <= '0;
        end else if (s1Load_s) begin
            s1Valid_r <= in_valid;
            if (in_valid) begin
                s1_r <= s1Next_s;
            end
        end
    end

    assign sum25_s = {1'b0, s1_r.manL} + {1'b0, s1_r.shifted};
    // manL >= shifted whenever L really is the larger magnitude.
    assign diff_s  = s1_r.manL - s1_r.shifted;

    // Stage-2 add/subtract, carry correction, overflow and sign fix-up.
    always_comb begin
        resNext_s      = 24'h00_0000;
        expNext_s      = 8'h00;
        signNext_s     = 1'b0;
        stickyNext_s   = 1'b0;
        spValidNext_s  = 1'b0;
        spResultNext_s = 32'h0000_0000;
        if (s1_r.special) begin
            spValidNext_s  = 1'b1;
            spResultNext_s = s1_r.specialResult;
        end else if (!s1_r.effSub && sum25_s[24] && (s1_r.expL == EXP_TOP)) begin
            spValidNext_s  = 1'b1;
            spResultNext_s = signedInf(s1_r.signL);
            expNext_s      = EXP_MAX;
        end else begin
            if (s1_r.effSub) begin
                resNext_s    = diff_s;
                stickyNext_s = s1_r.sticky;
                expNext_s    = s1_r.expL;
            end else if (sum25_s[24]) begin
                resNext_s    = sum25_s[24:1];
                stickyNext_s = s1_r.sticky | sum25_s[0];
                expNext_s    = s1_r.expL + 8'd1;
            end else begin
                resNext_s    = sum25_s[23:0];
                stickyNext_s = s1_r.sticky;
                expNext_s    = s1_r.expL;
            end
            if (s1_r.bothZero) begin
                signNext_s = s1_r.zeroSign;
            end else if ((resNext_s == 24'h00_0000) && !stickyNext_s) begin
                signNext_s = 1'b0;
            end else begin
                signNext_s = s1_r.signL;
            end
        end
    end

    // Stage-2 / output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2Valid_r       <= 1'b0;
            alignedResult_r <= 24'h00_0000;
            exponentOut_r   <= 8'h00;
            alignedSign_r   <= 1'b0;
            stickyBit_r     <= 1'b0;
            specialValid_r  <= 1'b0;
            specialResult_r <= 32'h0000_0000;
        end else if (s2Load_s) begin
            s2Valid_r <= s1Valid_r;
            if (s1Valid_r) begin
                alignedResult_r <= resNext_s;
                exponentOut_r   <= expNext_s;
                alignedSign_r   <= signNext_s;
                stickyBit_r     <= stickyNext_s;
                specialValid_r  <= spValidNext_s;
                specialResult_r <= spResultNext_s;
            end
        end
    end

    assign out_valid     = s2Valid_r;
    assign alignedResult = alignedResult_r;
    assign exponentOut   = exponentOut_r;
    assign alignedSign   = alignedSign_r;
    assign stickyBit     = stickyBit_r;
    assign specialValid  = specialValid_r;
    assign specialResult = specialResult_r;

endmodule

// File: tb/tb_fp_align_add.sv
// Self-checking bench for fp_align_add: hand-computed vector table driven
// through the handshake, expected records queued on input transfer and
// compared when the DUT hands a result over; plus latency, backpressure and
// mid-flight reset sequences.
module tb_fp_align_add;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opA = 32'h0;
    logic [31:0] opB = 32'h0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] alignedResult;
    logic [7:0]  exponentOut;
    logic        alignedSign;
    logic        stickyBit;
    logic        specialValid;
    logic [31:0] specialResult;

    fp_align_add dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opA           (opA),
        .opB           (opB),
        .sub           (sub),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alignedResult (alignedResult),
        .exponentOut   (exponentOut),
        .alignedSign   (alignedSign),
        .stickyBit     (stickyBit),
        .specialValid  (specialValid),
        .specialResult (specialResult)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [23:0] res;
        logic [7:0]  ex;
        logic        sign;
        logic        sticky;
        logic        spV;
        logic [31:0] spR;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    vec_t sbQ[$];
    int   total = 0;
    int   bad = 0;
    int   accepted = 0;
    int   popped = 0;
    bit   toggleDone = 1'b0;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input logic [23:0] res, input logic [7:0] ex, input logic sign,
                                input logic sticky, input logic spV, input logic [31:0] spR);
        vec_t v;
        v.a = a; v.b = b; v.sub = s; v.res = res; v.ex = ex;
        v.sign = sign; v.sticky = sticky; v.spV = spV; v.spR = spR;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkFields(input vec_t e);
        check("alignedResult", {8'h00, alignedResult}, {8'h00, e.res});
        check("exponentOut",   {24'h0, exponentOut},   {24'h0, e.ex});
        check("alignedSign",   {31'h0, alignedSign},   {31'h0, e.sign});
        check("stickyBit",     {31'h0, stickyBit},     {31'h0, e.sticky});
        check("specialValid",  {31'h0, specialValid},  {31'h0, e.spV});
        check("specialResult", specialResult,          e.spR);
    endtask

    // Scoreboard consumer: compare whenever a result is handed over.
    always @(negedge clk) begin
        vec_t e;
        if (!reset && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                check("spurious out_valid", {31'h0, out_valid}, 32'd0);
            end else begin
                e = sbQ.pop_front();
                popped++;
                checkFields(e);
            end
        end
    end

    // Present one op until it is accepted (bounded), queue its expectation.
    task automatic sendOp(input vec_t v);
        int waitCycles;
        waitCycles = 0;
        opA = v.a; opB = v.b; sub = v.sub; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            check("in_ready timeout", {31'h0, in_ready}, 32'd1);
        end else begin
            sbQ.push_back(v);
            accepted++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sbQ.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("drain queue empty", sbQ.size(), 32'd0);
    endtask

    initial begin
        int base;
        vecs[0]  = mk(32'h3F80_0000, 32'h3F80_0000, 1'b0, 24'h80_0000, 8'd128, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(32'h3F80_0000, 32'h3080_0000, 1'b0, 24'h80_0000, 8'd127, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[2]  = mk(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 24'h40_0000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(32'h4040_0000, 32'h4040_0000, 1'b1, 24'h00_0000, 8'd128, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[4]  = mk(32'h7F80_0000, 32'h3F80_0000, 1'b0, 24'h0, 8'd0, 1'b0, 1'b0, 1'b1, 32'h7F80_0000);
        vecs[5]  = mk(32'h7F80_0000, 32'h7F80_0000, 1'b1, 24'h0, 8'd0, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000);
        vecs[6]  = mk(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 24'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 32'h7F80_0000);
        vecs[7]  = mk(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 24'h0, 8'd0, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000);
        vecs[8]  = mk(32'h3F80_0000, 32'h4000_0000, 1'b1, 24'h40_0000, 8'd128, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[9]  = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 24'h0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[10] = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 24'h0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[11] = mk(32'h3F80_0000, 32'h7F80_0000, 1'b1, 24'h0, 8'd0, 1'b0, 1'b0, 1'b1, 32'hFF80_0000);
        vecs[12] = mk(32'hFF80_0000, 32'h7F80_0000, 1'b0, 24'h0, 8'd0, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000);
        vecs[13] = mk(32'h3F80_0000, 32'h3380_0000, 1'b0, 24'h80_0000, 8'd127, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[14] = mk(32'h3F80_0000, 32'h3400_0001, 1'b0, 24'h80_0001, 8'd127, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[15] = mk(32'h3F80_0000, 32'h3F80_0001, 1'b0, 24'h80_0000, 8'd128, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[16] = mk(32'h0000_0005, 32'h3F80_0000, 1'b0, 24'h80_0000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[17] = mk(32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 24'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 32'hFF80_0000);
        vecs[18] = mk(32'h3F80_0000, 32'h3380_0000, 1'b1, 24'h80_0000, 8'd127, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[19] = mk(32'hBF80_0000, 32'hBF80_0000, 1'b1, 24'h00_0000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state.
        #1;
        check("reset out_valid", {31'h0, out_valid}, 32'd0);
        check("reset alignedResult", {8'h00, alignedResult}, 32'd0);
        check("reset specialResult", specialResult, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("in_ready after reset", {31'h0, in_ready}, 32'd1);

        // Latency: one op on an empty pipeline.
        @(posedge clk); #1;
        sendOp(vecs[0]);
        @(negedge clk);
        check("latency early out_valid", {31'h0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency out_valid", {31'h0, out_valid}, 32'd1);
        drain();

        // Table, back-to-back with the consumer always ready.
        @(posedge clk); #1;
        for (int i = 0; i < NV; i++) sendOp(vecs[i]);
        drain();

        // Table again under random consumer stalls.
        @(posedge clk); #1;
        toggleDone = 1'b0;
        fork
            begin
                for (int i = 0; i < NV; i++) sendOp(vecs[NV - 1 - i]);
                toggleDone = 1'b1;
            end
            begin
                while (!toggleDone) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Backpressure: four ops with the consumer stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) sendOp(vecs[i]);
            end
            begin
                repeat (5) @(negedge clk);
                check("bp in_ready low", {31'h0, in_ready}, 32'd0);
                check("bp accepted", accepted, 32'd2);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp hold valid", {31'h0, out_valid}, 32'd1);
                    check("bp hold result", {8'h00, alignedResult}, {8'h00, sbQ[0].res});
                    check("bp hold exponent", {24'h0, exponentOut}, {24'h0, sbQ[0].ex});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                base = popped;
                repeat (4) @(negedge clk);
                #1;
                check("bp one per cycle", popped - base, 32'd4);
            end
        join
        drain();

        // Reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        sendOp(vecs[4]);
        sendOp(vecs[5]);
        @(negedge clk);
        check("pre-reset out_valid", {31'h0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset out_valid", {31'h0, out_valid}, 32'd0);
        check("async reset specialValid", {31'h0, specialValid}, 32'd0);
        sbQ.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post-reset no stale", {31'h0, out_valid}, 32'd0);
            check("post-reset in_ready", {31'h0, in_ready}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
